// File: rtl/spectrum_bank_pkg.sv
// Shared types and defaults for the spectrum double-bank controller.
// Writer FSM encoding and default geometry live here.
package spectrum_bank_pkg;

  localparam int BIN_AW_DEF = 9;
  localparam int DW_DEF     = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } wr_state_e;

endpackage

// File: rtl/spectrum_bank_ram.sv
// Two-bank storage as one simple dual-port RAM.
// Address MSB selects the bank; read data is registered.
module spectrum_bank_ram
  import spectrum_bank_pkg::*;
#(
  parameter int AW = BIN_AW_DEF + 1,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // Storage write and registered read; contents are never cleared.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/spectrum_bank_ctrl.sv
// Double-buffered spectrum bank controller: writer fills the back bank,
// display reads the front bank. Optional stats: SPECTRUM_BANK_STATS_EN.
module spectrum_bank_ctrl
  import spectrum_bank_pkg::*;
#(
  parameter int BIN_AW = BIN_AW_DEF,
  parameter int DW     = DW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DW-1:0]     wr_data,
  input  logic              wr_last,
  input  logic              i_frame,
  input  logic              i_rd_en,
  input  logic [BIN_AW-1:0] i_rd_addr,
  output logic [DW-1:0]     o_rd_data,
  output logic              o_rd_valid,
  output logic              o_front_bank,
  output logic [BIN_AW:0]   o_front_len
`ifdef SPECTRUM_BANK_STATS_EN
  ,
  output logic [15:0]       o_swap_count,
  output logic [15:0]       o_stall_count
`endif
);

  localparam logic [BIN_AW-1:0] ADDR_MAX = '1;
  localparam logic [BIN_AW-1:0] ADDR_ONE = 1;
  localparam logic [BIN_AW:0]   LEN_ONE  = 1;

  wr_state_e         state_q, state_d;
  logic [BIN_AW-1:0] waddr_q, waddr_d;
  logic [BIN_AW:0]   fill_len_q, fill_len_d;
  logic              front_q, front_d;
  logic [BIN_AW:0]   front_len_q, front_len_d;
  logic              ram_we;
  logic              swap;

  logic              rd_v1_q;
  logic              rd_oor1_q;
  logic              rd_valid_q;
  logic [DW-1:0]     rd_data_q;
  logic [DW-1:0]     ram_rdata;

  // Writer FSM next state, bank swap and write strobe.
  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    fill_len_d  = fill_len_q;
    front_d     = front_q;
    front_len_d = front_len_q;
    wr_ready    = 1'b0;
    ram_we      = 1'b0;
    swap        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_FILL;
        waddr_d = '0;
      end
      ST_FILL: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          ram_we = 1'b1;
          if (wr_last || waddr_q == ADDR_MAX) begin
            state_d    = ST_DONE;
            fill_len_d = {1'b0, waddr_q} + LEN_ONE;
          end else begin
            waddr_d = waddr_q + ADDR_ONE;
          end
        end
      end
      ST_DONE: begin
        if (i_frame) begin
          swap        = 1'b1;
          front_d     = ~front_q;
          front_len_d = fill_len_q;
          waddr_d     = '0;
          state_d     = ST_FILL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Writer FSM and front-bank registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      waddr_q     <= '0;
      fill_len_q  <= '0;
      front_q     <= 1'b0;
      front_len_q <= '0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      fill_len_q  <= fill_len_d;
      front_q     <= front_d;
      front_len_q <= front_len_d;
    end
  end

  // Read pipeline: range check alongside the RAM read, zero out-of-range.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_v1_q    <= 1'b0;
      rd_oor1_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_v1_q    <= i_rd_en;
      rd_oor1_q  <= ({1'b0, i_rd_addr} >= front_len_q);
      rd_valid_q <= rd_v1_q;
      rd_data_q  <= (rd_v1_q && !rd_oor1_q) ? ram_rdata : '0;
    end
  end

  spectrum_bank_ram #(
    .AW (BIN_AW + 1),
    .DW (DW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i ({~front_q, waddr_q}),
    .wdata_i (wr_data),
    .re_i    (i_rd_en),
    .raddr_i ({front_q, i_rd_addr}),
    .rdata_o (ram_rdata)
  );

  assign o_rd_data    = rd_data_q;
  assign o_rd_valid   = rd_valid_q;
  assign o_front_bank = front_q;
  assign o_front_len  = front_len_q;

`ifdef SPECTRUM_BANK_STATS_EN
  logic [15:0] swap_cnt_q;
  logic [15:0] stall_cnt_q;

  // Swap counter wraps; stall counter saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      swap_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (swap) swap_cnt_q <= swap_cnt_q + 16'd1;
      if (wr_valid && !wr_ready && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign o_swap_count  = swap_cnt_q;
  assign o_stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_spectrum_bank_ctrl.sv
// Self-checking bench for spectrum_bank_ctrl (default geometry).
// Read results go through a latency-tagged scoreboard queue.
module tb_spectrum_bank_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic        wr_last;
  logic        i_frame;
  logic        i_rd_en;
  logic [8:0]  i_rd_addr;
  logic [15:0] o_rd_data;
  logic        o_rd_valid;
  logic        o_front_bank;
  logic [9:0]  o_front_len;
`ifdef SPECTRUM_BANK_STATS_EN
  logic [15:0] o_swap_count;
  logic [15:0] o_stall_count;
`endif

  spectrum_bank_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .wr_last      (wr_last),
    .i_frame      (i_frame),
    .i_rd_en      (i_rd_en),
    .i_rd_addr    (i_rd_addr),
    .o_rd_data    (o_rd_data),
    .o_rd_valid   (o_rd_valid),
    .o_front_bank (o_front_bank),
    .o_front_len  (o_front_len)
`ifdef SPECTRUM_BANK_STATS_EN
    ,
    .o_swap_count (o_swap_count),
    .o_stall_count(o_stall_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    int          due;
    logic [15:0] d;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [8:0]  addr;
    logic [15:0] exp;
  } rvec_t;

  // reference model
  logic [15:0] mbank [2][512];
  int          mst;
  int          maddr;
  int          mfill;
  int          mfront;
  int          mlen;
  int          mswap;
  int          mstall;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad < 60)
        $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) t=%0t",
                 nm, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [15:0] mread(input logic [8:0] a);
    if (int'(a) < mlen) return mbank[mfront][a];
    return 16'h0;
  endfunction

  task automatic mreset();
    mst = 0; maddr = 0; mfill = 0;
    mfront = 0; mlen = 0; mswap = 0; mstall = 0;
    sbq.delete();
  endtask

  // read monitor: checks latency and data against the scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (o_rd_valid) begin
        if (sbq.size() == 0) begin
          chk("rd_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("rd_latency", cyc, e.due);
          chk("rd_data", int'(o_rd_data), int'(e.d));
        end
      end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
        exp_t e;
        e = sbq.pop_front();
        chk("rd_missing", 0, 1);
      end
    end
  end

  // One clock of stimulus; model advances from its pre-edge state.
  task automatic step(input logic v, input logic [15:0] d,
                      input logic l, input logic f,
                      input logic r, input logic [8:0] ra,
                      input logic use_exp, input logic [15:0] ed);
    exp_t e;
    wr_valid = v; wr_data = d; wr_last = l;
    i_frame = f; i_rd_en = r; i_rd_addr = ra;
    chk("wr_ready", int'(wr_ready), (mst == 1) ? 1 : 0);
    if (r) begin
      e.due = cyc + 2;
      e.d   = use_exp ? ed : mread(ra);
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    if (v && mst != 1 && mstall < 65535) mstall++;
    case (mst)
      0: begin mst = 1; maddr = 0; end
      1: if (v) begin
        mbank[mfront ^ 1][maddr] = d;
        if (l || maddr == 511) begin
          mst = 2; mfill = maddr + 1;
        end else begin
          maddr++;
        end
      end
      default: if (f) begin
        mfront = mfront ^ 1; mlen = mfill;
        maddr = 0; mst = 1; mswap = (mswap + 1) % 65536;
      end
    endcase
    chk("front_bank", int'(o_front_bank), mfront);
    chk("front_len", int'(o_front_len), mlen);
`ifdef SPECTRUM_BANK_STATS_EN
    chk("swap_count", int'(o_swap_count), mswap);
    chk("stall_count", int'(o_stall_count), mstall);
`endif
    wr_valid = 0; wr_last = 0; i_frame = 0; i_rd_en = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic fill(input int n, input logic [15:0] base,
                      input logic last);
    for (int i = 0; i < n; i++)
      step(1, base + 16'(i), last && (i == n - 1), 0, 0, 0, 0, 0);
  endtask

  task automatic frame();
    step(0, 0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_wr_ready"}, int'(wr_ready), 0);
    chk({nm, "_rd_valid"}, int'(o_rd_valid), 0);
    chk({nm, "_rd_data"}, int'(o_rd_data), 0);
    chk({nm, "_front_bank"}, int'(o_front_bank), 0);
    chk({nm, "_front_len"}, int'(o_front_len), 0);
`ifdef SPECTRUM_BANK_STATS_EN
    chk({nm, "_swap_cnt"}, int'(o_swap_count), 0);
    chk({nm, "_stall_cnt"}, int'(o_stall_count), 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rvec_t t1[5];
    rvec_t t2[6];
    rvec_t t3[3];
    int    lowcnt;

    t1[0] = '{9'd5,   16'hA005};
    t1[1] = '{9'd0,   16'hA000};
    t1[2] = '{9'd256, 16'hA100};
    t1[3] = '{9'd511, 16'hA1FF};
    t1[4] = '{9'd6,   16'hA006};

    t2[0] = '{9'd0,   16'h5000};
    t2[1] = '{9'd99,  16'h5063};
    t2[2] = '{9'd100, 16'h0000};
    t2[3] = '{9'd150, 16'h0000};
    t2[4] = '{9'd511, 16'h0000};
    t2[5] = '{9'd42,  16'h502A};

    t3[0] = '{9'd0,  16'hB000};
    t3[1] = '{9'd19, 16'hB013};
    t3[2] = '{9'd20, 16'h0000};

    reset = 1; wr_valid = 0; wr_data = 0; wr_last = 0;
    i_frame = 0; i_rd_en = 0; i_rd_addr = 0;
    mreset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("por");
    reset = 0;

    // IDLE -> FILL, then 512 beats with last on beat 511
    idle(1);
    fill(512, 16'hA000, 1);
    idle(1);
    frame();
    chk("full_bank", int'(o_front_bank), 1);
    chk("full_len", int'(o_front_len), 512);
    for (int i = 0; i < 5; i++)
      step(0, 0, 0, 0, 1, t1[i].addr, 1, t1[i].exp);
    idle(3);

    // 100-bin spectrum, 30 stalled cycles in DONE, then swap
    fill(100, 16'h5000, 1);
    lowcnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (!wr_ready) lowcnt++;
      step(1, 16'hDEAD, 0, 0, 0, 0, 0, 0);
    end
    chk("stall_ready_low", lowcnt, 30);
`ifdef SPECTRUM_BANK_STATS_EN
    chk("stall_30", int'(o_stall_count), 30);
`endif
    frame();
    chk("len100", int'(o_front_len), 100);
    chk("len100_bank", int'(o_front_bank), 0);
    for (int i = 0; i < 6; i++)
      step(0, 0, 0, 0, 1, t2[i].addr, 1, t2[i].exp);
    idle(3);

    // frame during FILL is ignored
    fill(10, 16'h7000, 0);
    frame();
    chk("frame_in_fill", int'(o_front_bank), 0);
    fill(20, 16'h700A, 1);
    frame();
    chk("frame_after_done", int'(o_front_bank), 1);
    chk("len30", int'(o_front_len), 30);
    step(0, 0, 0, 0, 1, 9'd12, 0, 0);
    step(0, 0, 0, 0, 1, 9'd29, 0, 0);
    idle(3);

    // last beat coincident with frame: no swap until next frame
    fill(39, 16'h8000, 0);
    step(1, 16'h8027, 1, 1, 0, 0, 0, 0);
    chk("coincide_noswap", int'(o_front_bank), 1);
    frame();
    chk("coincide_swap", int'(o_front_bank), 0);
    chk("len40", int'(o_front_len), 40);
    step(0, 0, 0, 0, 1, 9'd39, 0, 0);
    idle(3);

    // forced wrap-stop after 512 beats without last
    fill(512, 16'h3000, 0);
    idle(1);
    frame();
    chk("wrap_len", int'(o_front_len), 512);
    step(0, 0, 0, 0, 1, 9'd511, 0, 0);
    idle(3);

    // reset mid-fill with reads still in flight
    fill(198, 16'h9000, 0);
    step(1, 16'h90C6, 0, 0, 1, 9'd7, 0, 0);
    step(1, 16'h90C7, 0, 0, 1, 9'd8, 0, 0);
    reset = 1;
    #1;
    chk_reset_outs("midfill");
    mreset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("held");
    reset = 0;
    idle(1);
    fill(20, 16'hB000, 1);
    frame();
    chk("refill_bank", int'(o_front_bank), 1);
    chk("refill_len", int'(o_front_len), 20);
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 0, 1, t3[i].addr, 1, t3[i].exp);
    idle(4);
    chk("sb_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spectrum_bank_ctrl.md
SPECTRUM_BANK_CTRL -- requirements
Module: spectrum_bank_ctrl

Interface
REQ-001 SHALL have parameter BIN_AW, default 9, bin address width (2^BIN_AW bins per bank).
REQ-002 SHALL have parameter DW, default 16, bin magnitude width.
REQ-003 SHALL have port clk, input, 1, the single pixel-domain clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port wr_valid, input, 1, writer presents a bin.
REQ-006 SHALL have port wr_ready, output, 1, controller accepts the bin.
REQ-007 SHALL have port wr_data, input, DW, bin magnitude.
REQ-008 SHALL have port wr_last, input, 1, marks the final bin of a spectrum.
REQ-009 SHALL have port i_frame, input, 1, one-cycle pulse at display frame start.
REQ-010 SHALL have port i_rd_en, input, 1, display read strobe.
REQ-011 SHALL have port i_rd_addr, input, BIN_AW, display read bin index.
REQ-012 SHALL have port o_rd_data, output, DW, read data from the front bank.
REQ-013 SHALL have port o_rd_valid, output, 1, qualifies o_rd_data.
REQ-014 SHALL have port o_front_bank, output, 1, index of the bank currently displayed.
REQ-015 SHALL have port o_front_len, output, BIN_AW+1, number of valid bins in the front bank.

Function
REQ-016 SHALL hold two banks of 2^BIN_AW x DW: the front bank is read by the display and the back bank is written by the writer.
REQ-017 SHALL implement writer FSM states IDLE, FILL and DONE.
REQ-018 IDLE SHALL move to FILL on the first clock after reset release, with the write address set to 0.
REQ-019 In FILL, wr_ready SHALL be 1, and each wr_valid&&wr_ready SHALL write wr_data to the back bank at the write address, then increment the address.
REQ-020 FILL SHALL move to DONE on an accepted beat carrying wr_last, or on an accepted beat at address 2^BIN_AW-1 (forced wrap-stop); the fill length SHALL be latched as address+1.
REQ-021 In IDLE and DONE, wr_ready SHALL be 0, and wr_valid SHALL be ignored.
REQ-022 In DONE, an i_frame pulse SHALL swap banks: o_front_bank toggles, o_front_len takes the latched fill length, the address clears to 0 and the FSM moves to FILL, all in one cycle.
REQ-023 An i_frame pulse in FILL or IDLE SHALL have no effect; the front bank is repeated.
REQ-024 When the wr_last beat and i_frame coincide in FILL, the FSM SHALL enter DONE only; the swap occurs on the next i_frame.
REQ-025 Read latency SHALL be 2 cycles: o_rd_valid equals i_rd_en delayed 2, and o_rd_data comes from the bank that was front in the i_rd_en cycle.
REQ-026 Reads with i_rd_addr >= o_front_len SHALL return 0 with o_rd_valid still asserted.
REQ-027 Read and write ports SHALL never target the same bank in the same cycle.

Reset
REQ-028 Asserting reset SHALL immediately force: FSM IDLE, write address 0, wr_ready 0, o_rd_valid 0, o_rd_data 0, o_front_bank 0, o_front_len 0, and all stats counters 0.
REQ-029 Reset mid-fill SHALL discard the partial spectrum; RAM contents need not be cleared.

Configuration
REQ-030 When macro SPECTRUM_BANK_STATS_EN is defined, the block SHALL add output o_swap_count (16 bits, increments per swap, wraps) and output o_stall_count (16 bits, counts cycles with wr_valid=1 and wr_ready=0, saturates at 0xFFFF).
REQ-031 When SPECTRUM_BANK_STATS_EN is undefined, those ports and their counters SHALL be absent.

Structure
REQ-032 The shared package SHALL hold the FSM state encoding (IDLE=0, FILL=1, DONE=2) and the default values of BIN_AW and DW.
REQ-033 Bank storage SHALL be a single sub-module, spectrum_bank_ram: a simple dual-port RAM with one write port and one registered read port, with the bank selected by the address MSB.

Verification
REQ-034 Reset release, then 512 beats with wr_last on beat 511, then i_frame -> o_front_bank=1 and o_front_len=512 one cycle after i_frame; a read at addr 5 returns beat 5 two cycles later.
REQ-035 Spectrum of 100 bins, then swap -> o_front_len=100; a read at addr 150 returns 0 with o_rd_valid=1.
REQ-036 wr_valid held high after DONE for 30 cycles before i_frame -> wr_ready=0 for those 30 cycles; with STATS_EN, o_stall_count=30.
REQ-037 i_frame during FILL, then again after DONE -> the first pulse leaves o_front_bank unchanged; the second pulse toggles it.
REQ-038 wr_last beat coincident with i_frame -> no swap that cycle; swap on the next i_frame.
REQ-039 reset pulsed after 200 beats of a fill -> all outputs return to reset values; the next fill restarts at address 0.
